// File: rtl/writeback_stage_if.sv
// Bundle of execute-side, memory-side and register-file-side signals for writeback_stage.
// slave is the stage's view; master is the surrounding pipeline/memory view.
interface writeback_stage_if #(
  parameter int MACHINE_WIDTH = 32,
  parameter int REG_ADDR_W    = 6,
  parameter int WARP_ID_W     = 3
) ();
  logic                     ex_valid;
  logic                     ex_ready;
  logic [MACHINE_WIDTH-1:0] ex_result;
  logic [REG_ADDR_W-1:0]    ex_rd;
  logic [WARP_ID_W-1:0]     ex_warp;
  logic                     ex_reg_wen;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic [MACHINE_WIDTH-1:0] ex_store_data;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_write;
  logic [MACHINE_WIDTH-1:0] mem_req_addr;
  logic [MACHINE_WIDTH-1:0] mem_req_wdata;
  logic                     mem_rsp_valid;
  logic [MACHINE_WIDTH-1:0] mem_rsp_data;

  logic                     rf_wen;
  logic [WARP_ID_W-1:0]     rf_warp;
  logic [REG_ADDR_W-1:0]    rf_waddr;
  logic [MACHINE_WIDTH-1:0] rf_wdata;
  logic                     busy;

  modport slave (
    input  ex_valid, ex_result, ex_rd, ex_warp, ex_reg_wen, ex_mem_read, ex_mem_write,
           ex_store_data, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output ex_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
           rf_wen, rf_warp, rf_waddr, rf_wdata, busy
  );

  modport master (
    output ex_valid, ex_result, ex_rd, ex_warp, ex_reg_wen, ex_mem_read, ex_mem_write,
           ex_store_data, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  ex_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
           rf_wen, rf_warp, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/writeback_stage.sv
// Execute-to-writeback stage: input FIFO, load/store request sequencing, one RF write per instruction.
// Optional WB_BYPASS_EN: an ALU result arriving at an idle, empty stage skips the FIFO.
module writeback_stage #(
  parameter int MACHINE_WIDTH = 32,
  parameter int REG_ADDR_W    = 6,
  parameter int WARP_ID_W     = 3,
  parameter int FIFO_DEPTH    = 2
) (
  input logic             clk,
  input logic             reset,
  writeback_stage_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  logic [MACHINE_WIDTH-1:0] q_result [FIFO_DEPTH];
  logic [MACHINE_WIDTH-1:0] q_sdata  [FIFO_DEPTH];
  logic [REG_ADDR_W-1:0]    q_rd     [FIFO_DEPTH];
  logic [WARP_ID_W-1:0]     q_warp   [FIFO_DEPTH];
  logic                     q_wen    [FIFO_DEPTH];
  logic                     q_mem    [FIFO_DEPTH];
  logic                     q_store  [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       state, state_next;
  logic             full, empty, ready, push, push_fifo, pop, bypass;
  logic             head_mem, head_store, in_req;

  logic                     rf_wen_q, rf_wen_next;
  logic [WARP_ID_W-1:0]     rf_warp_q, rf_warp_next;
  logic [REG_ADDR_W-1:0]    rf_waddr_q, rf_waddr_next;
  logic [MACHINE_WIDTH-1:0] rf_wdata_q, rf_wdata_next;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign ready      = ~full;
  assign push       = bus.ex_valid & ready;
  assign head_mem   = q_mem[rd_ptr];
  assign head_store = q_store[rd_ptr];
  assign in_req     = (state == MEM_REQ);

`ifdef WB_BYPASS_EN
  assign bypass = push & empty & (state == IDLE) & ~bus.ex_mem_read & ~bus.ex_mem_write;
`else
  assign bypass = 1'b0;
`endif
  assign push_fifo = push & ~bypass;

  always_ff @(posedge clk) begin
    if (push_fifo) begin
      q_result[wr_ptr] <= bus.ex_result;
      q_sdata[wr_ptr]  <= bus.ex_store_data;
      q_rd[wr_ptr]     <= bus.ex_rd;
      q_warp[wr_ptr]   <= bus.ex_warp;
      q_wen[wr_ptr]    <= bus.ex_reg_wen;
      q_mem[wr_ptr]    <= bus.ex_mem_read | bus.ex_mem_write;
      // read has priority, so an entry flagged both ways is a load
      q_store[wr_ptr]  <= ~bus.ex_mem_read & bus.ex_mem_write;
    end
  end

  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    rf_wen_next   = 1'b0;
    rf_warp_next  = rf_warp_q;
    rf_waddr_next = rf_waddr_q;
    rf_wdata_next = rf_wdata_q;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_mem) begin
            state_next = MEM_REQ;
          end else begin
            pop         = 1'b1;
            rf_wen_next = q_wen[rd_ptr];
            if (q_wen[rd_ptr]) begin
              rf_warp_next  = q_warp[rd_ptr];
              rf_waddr_next = q_rd[rd_ptr];
              rf_wdata_next = q_result[rd_ptr];
            end
          end
        end else if (bypass) begin
          rf_wen_next = bus.ex_reg_wen;
          if (bus.ex_reg_wen) begin
            rf_warp_next  = bus.ex_warp;
            rf_waddr_next = bus.ex_rd;
            rf_wdata_next = bus.ex_result;
          end
        end
      end
      MEM_REQ: begin
        if (bus.mem_req_ready) begin
          if (head_store) begin
            pop        = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (bus.mem_rsp_valid) begin
          pop         = 1'b1;
          state_next  = IDLE;
          rf_wen_next = q_wen[rd_ptr];
          if (q_wen[rd_ptr]) begin
            rf_warp_next  = q_warp[rd_ptr];
            rf_waddr_next = q_rd[rd_ptr];
            rf_wdata_next = bus.mem_rsp_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rf_wen_q   <= 1'b0;
      rf_warp_q  <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state      <= state_next;
      rf_wen_q   <= rf_wen_next;
      rf_warp_q  <= rf_warp_next;
      rf_waddr_q <= rf_waddr_next;
      rf_wdata_q <= rf_wdata_next;
      if (push_fifo) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({push_fifo, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.ex_ready      = ready;
  assign bus.mem_req_valid = in_req;
  assign bus.mem_req_write = in_req & head_store;
  assign bus.mem_req_addr  = in_req ? q_result[rd_ptr] : '0;
  assign bus.mem_req_wdata = in_req ? q_sdata[rd_ptr]  : '0;
  assign bus.rf_wen        = rf_wen_q;
  assign bus.rf_warp       = rf_warp_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.busy          = ~empty | (state != IDLE) | rf_wen_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a stimulus driver queues expected RF writes and memory
// requests from an instruction-level model; memory responder and RF monitor pop and compare.
`timescale 1ns/1ps
module tb_writeback_stage;
  localparam int MW = 32;
  localparam int RW = 6;
  localparam int WW = 3;
  localparam int FD = 2;
`ifdef WB_BYPASS_EN
  localparam int ALU_LAT = 1;
`else
  localparam int ALU_LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  writeback_stage_if #(.MACHINE_WIDTH(MW), .REG_ADDR_W(RW), .WARP_ID_W(WW)) bus ();

  writeback_stage #(.MACHINE_WIDTH(MW), .REG_ADDR_W(RW), .WARP_ID_W(WW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WW-1:0] warp;
    logic [RW-1:0] rd;
    logic [MW-1:0] data;
    int            due;
    bit            is_load;
  } rf_exp_t;

  typedef struct {
    logic          write;
    logic [MW-1:0] addr;
    logic [MW-1:0] wdata;
    int            due;
  } req_exp_t;

  rf_exp_t  rf_q[$];
  req_exp_t req_q[$];
  int tests = 0;
  int fails = 0;

  // memory responder knobs and state
  int            req_stall = -1;
  int            rsp_delay = -1;
  bit            rsp_hold = 0;
  bit            stray_req = 0;
  int            rsp_cnt = 0;
  logic [MW-1:0] rsp_addr = '0;
  int            last_rsp_cyc = -10;
  int            last_hs_cyc = -10;
  int            last_rf_cyc = -10;
  int            rf_seen = 0;

  // memory contents as seen by loads
  function automatic logic [MW-1:0] load_val(input logic [MW-1:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.ex_ready, bus.rf_wen, bus.rf_warp, bus.rf_waddr, bus.rf_wdata,
                 bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.mem_req_wdata,
                 bus.busy}, {1'b1, 109'd0});
  endtask

  // memory side: decides ready, checks request order/contents/stability, returns load data
  initial begin
    int            first_cyc;
    int            valid_cnt;
    logic [MW*2:0] saved;
    req_exp_t      e;
    first_cyc = -1;
    valid_cnt = 0;
    saved = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if (!reset) begin
        rsp_cnt = 0;
        first_cyc = -1;
        valid_cnt = 0;
        bus.mem_req_ready = 1'b0;
        continue;
      end
      if (stray_req) begin
        stray_req = 0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hBAD0_0BAD;
      end else if (rsp_cnt > 0 && !rsp_hold) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = load_val(rsp_addr);
          last_rsp_cyc = cyc;
        end
      end
      if (bus.mem_req_valid) begin
        valid_cnt++;
        if (first_cyc < 0) begin
          first_cyc = cyc;
          saved = {bus.mem_req_write, bus.mem_req_addr, bus.mem_req_wdata};
        end else begin
          check("req_stable", {bus.mem_req_write, bus.mem_req_addr, bus.mem_req_wdata}, saved);
        end
        bus.mem_req_ready = (req_stall < 0) ? 1'($urandom_range(0, 1)) : (valid_cnt > req_stall);
        if (bus.mem_req_ready) begin
          if (req_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL req_unexpected: got addr 0x%0h write %0d, expected no request",
                     bus.mem_req_addr, bus.mem_req_write);
          end else begin
            e = req_q.pop_front();
            check("req_fields", {bus.mem_req_write, bus.mem_req_addr, bus.mem_req_wdata},
                  {e.write, e.addr, e.wdata});
            if (e.due >= 0) check("req_latency", first_cyc, e.due);
            if (req_stall >= 0) check("req_hold_cycles", valid_cnt, req_stall + 1);
          end
          if (!bus.mem_req_write) begin
            rsp_addr = bus.mem_req_addr;
            rsp_cnt  = (rsp_delay < 0) ? int'($urandom_range(1, 4)) : rsp_delay;
          end
          last_hs_cyc = cyc;
          first_cyc = -1;
          valid_cnt = 0;
        end
      end else begin
        bus.mem_req_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // register-file monitor
  initial begin
    rf_exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.rf_wen) begin
        rf_seen++;
        last_rf_cyc = cyc;
        if (rf_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rf_unexpected: got warp %0d rd %0d data 0x%0h, expected no write",
                   bus.rf_warp, bus.rf_waddr, bus.rf_wdata);
        end else begin
          e = rf_q.pop_front();
          check("rf_write", {bus.rf_warp, bus.rf_waddr, bus.rf_wdata}, {e.warp, e.rd, e.data});
          if (e.due >= 0) check("rf_latency", cyc, e.due);
          if (e.is_load) check("rf_load_latency", cyc, last_rsp_cyc + 1);
        end
      end
    end
  end

  // cls: 0 ALU, 1 load, 2 store, 3 load+store flags (load wins). lat<0 means latency unchecked.
  task automatic send(input int cls, input logic [RW-1:0] rd, input logic [WW-1:0] warp,
                      input logic [MW-1:0] res, input logic [MW-1:0] sd, input logic wen,
                      input int lat, output int acc, output int waited);
    bit is_load, is_store;
    is_load  = (cls == 1) || (cls == 3);
    is_store = (cls == 2);
    bus.ex_valid      = 1'b1;
    bus.ex_rd         = rd;
    bus.ex_warp       = warp;
    bus.ex_result     = res;
    bus.ex_store_data = sd;
    bus.ex_reg_wen    = wen;
    bus.ex_mem_read   = is_load;
    bus.ex_mem_write  = (cls == 2) || (cls == 3);
    acc = -1;
    waited = 0;
    while (acc < 0) begin
      @(negedge clk);
      if (bus.ex_ready) acc = cyc;
      else if (++waited > 300) begin
        tests++;
        fails++;
        $display("FAIL ex_accept_timeout: got ex_ready 0 for %0d cycles, expected acceptance", waited);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.ex_valid = 1'b0;
    if (acc >= 0) begin
      if (is_load || is_store)
        req_q.push_back('{write: is_store, addr: res, wdata: sd, due: (lat < 0) ? -1 : acc + lat});
      if (wen && is_load)
        rf_q.push_back('{warp: warp, rd: rd, data: load_val(res), due: -1, is_load: 1'b1});
      else if (wen && !is_store)
        rf_q.push_back('{warp: warp, rd: rd, data: res, due: (lat < 0) ? -1 : acc + lat, is_load: 1'b0});
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while ((rf_q.size() != 0 || req_q.size() != 0 || bus.busy) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, {bus.busy, rf_q.size() != 0, req_q.size() != 0}, 3'b000);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, w0, w1, seen;
    bus.ex_valid = 1'b0;
    bus.ex_result = '0;
    bus.ex_rd = '0;
    bus.ex_warp = '0;
    bus.ex_reg_wen = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_mem_write = 1'b0;
    bus.ex_store_data = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    reset = 1'b1;
    idle_cycles(2);

    // back-to-back ALU ops
    send(0, 6'd3, 3'd1, 32'h10, 32'h0, 1'b1, ALU_LAT, a0, w0);
    send(0, 6'd4, 3'd1, 32'h20, 32'h0, 1'b1, ALU_LAT, a1, w1);
    check("b2b_ready_held", w0 + w1, 0);
    check("b2b_adjacent_accept", a1 - a0, 1);
    drain("b2b_drain");

    // single ALU into empty stage, register 0 written
    send(0, 6'd0, 3'd5, 32'hCAFE_0001, 32'h0, 1'b1, ALU_LAT, a0, w0);
    drain("single_alu_drain");

    // load with ready held low for 3 cycles
    req_stall = 3;
    rsp_delay = 2;
    send(1, 6'd7, 3'd2, 32'h100, 32'h0, 1'b1, 2, a0, w0);
    drain("load_stall_drain");

    // store (reg_wen set, must not write) then ALU
    req_stall = 1;
    send(2, 6'd9, 3'd0, 32'h40, 32'h55, 1'b1, 2, a0, w0);
    send(0, 6'd5, 3'd3, 32'h77, 32'h0, 1'b1, -1, a1, w1);
    drain("store_alu_drain");
    check("alu_after_store_handshake", last_rf_cyc > last_hs_cyc, 1'b1);

    // load stalled in MEM_WAIT fills the FIFO
    req_stall = 0;
    rsp_delay = 1;
    rsp_hold  = 1;
    send(1, 6'd12, 3'd4, 32'h2000, 32'h0, 1'b1, -1, a0, w0);
    send(0, 6'd13, 3'd4, 32'h1313, 32'h0, 1'b1, -1, a1, w1);
    idle_cycles(4);
    check("full_ex_ready_low", bus.ex_ready, 1'b0);
    check("full_busy", bus.busy, 1'b1);
    fork
      begin
        repeat (6) @(posedge clk);
        rsp_hold = 0;
      end
    join_none
    send(0, 6'd14, 3'd4, 32'h1414, 32'h0, 1'b1, -1, a0, w0);
    check("full_push_waited", w0 >= 5, 1'b1);
    drain("full_drain");
    seen = rf_seen;
    stray_req = 1;
    idle_cycles(4);
    check("idle_rsp_ignored", {rf_seen - seen, bus.busy}, 0);

    // reset while a load sits in MEM_WAIT behind a full FIFO
    rsp_hold = 1;
    send(1, 6'd20, 3'd6, 32'h3000, 32'h0, 1'b1, -1, a0, w0);
    send(0, 6'd21, 3'd6, 32'h2121, 32'h0, 1'b1, -1, a1, w1);
    idle_cycles(4);
    #2;
    reset = 1'b0;
    rf_q.delete();
    req_q.delete();
    #1;
    check_reset_outputs("reset_mid_async");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_held");
    reset = 1'b1;
    rsp_hold = 0;
    seen = rf_seen;
    idle_cycles(1);
    stray_req = 1;
    idle_cycles(5);
    check("post_reset_rsp_ignored", {rf_seen - seen, bus.busy, bus.ex_ready}, 1);

    // randomized mix
    req_stall = -1;
    rsp_delay = -1;
    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, 3)), RW'($urandom), WW'($urandom), $urandom, $urandom,
           1'($urandom_range(0, 3) != 0), -1, a0, w0);
      idle_cycles(int'($urandom_range(0, 2)));
    end
    drain("random_drain");
    check("final_ready", bus.ex_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Execute-to-writeback stage directly downstream of the per-lane functional unit.
- Buffers each completed execute result, with its destination register and warp tag, in a small FIFO.
- Turns ld/st results (the computed address) into memory requests and waits for load data.
- Issues one register-file write per completed instruction.

Parameters:
MACHINE_WIDTH, 32, datapath width; matches functional unit alu_out
REG_ADDR_W, 6, register-file address width
WARP_ID_W, 3, warp tag width
FIFO_DEPTH, 2, input buffer entries; power of 2, >= 2

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ex_valid  in  1  execute result valid
ex_ready  out  1  stage can accept; transfer when ex_valid & ex_ready
ex_result  in  MACHINE_WIDTH  functional unit alu_out (ALU result or memory address)
ex_rd  in  REG_ADDR_W  destination register
ex_warp  in  WARP_ID_W  warp tag
ex_reg_wen  in  1  instruction writes a register
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_store_data  in  MACHINE_WIDTH  store data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1 = store, 0 = load
mem_req_addr  out  MACHINE_WIDTH  request address
mem_req_wdata  out  MACHINE_WIDTH  store data
mem_rsp_valid  in  1  load data valid (single-cycle pulse)
mem_rsp_data  in  MACHINE_WIDTH  load data
rf_wen  out  1  register-file write strobe (one-cycle pulse)
rf_warp  out  WARP_ID_W  write warp
rf_waddr  out  REG_ADDR_W  write register
rf_wdata  out  MACHINE_WIDTH  write data
busy  out  1  FIFO non-empty, or FSM not IDLE, or rf_wen high

Behaviour:
- Reset (reset==0, asynchronous): FIFO emptied, pointers 0, FSM to IDLE. All outputs 0 except ex_ready=1. Takes effect mid-operation; an in-flight memory request or response is dropped.
- FIFO: push on ex_valid & ex_ready. ex_ready = !full, registered-count based; no push when full even if a pop occurs the same cycle. Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop when neither full nor empty keeps the count unchanged.
- Entry class: mem_read=1 gives LOAD, and mem_read takes priority if both are set. Else mem_write=1 gives STORE. Else ALU.
- FSM states: IDLE, MEM_REQ, MEM_WAIT. The FSM always operates on the FIFO head.
- IDLE, head ALU: pop. If reg_wen, register rf_* = {1, warp, rd, result}; otherwise rf_wen=0. Stay IDLE; sustains 1 ALU op/cycle.
- IDLE, head LOAD/STORE: go to MEM_REQ with no pop.
- IDLE, FIFO empty: rf_wen=0.
- MEM_REQ: mem_req_valid=1; addr=head.result, write=class STORE, wdata=head.store_data. All four held stable until mem_req_ready.
  - On ready, STORE: pop, go to IDLE, no rf write.
  - On ready, LOAD: go to MEM_WAIT, mem_req_valid drops the next cycle.
- MEM_WAIT: on mem_rsp_valid, pop and go to IDLE. If head.reg_wen, register rf_* = {1, warp, rd, mem_rsp_data}.
- mem_rsp_valid outside MEM_WAIT is ignored.
- rf_* are registered outputs; rf_wen lasts exactly one cycle per write. Register 0 is written like any other register.
- Latency, FIFO empty:
  - ALU accepted in cycle N: rf_wen high in cycle N+2.
  - LOAD: mem_req_valid high in N+2. With ready in that cycle and rsp in cycle M, rf_wen is high in M+1.
- Ordering: writes are issued in acceptance order. A younger ALU op waits behind an older pending load.

Optional Feature:
WB_BYPASS_EN:
- Defined: if the FIFO is empty, the FSM is IDLE, and the accepted instruction is ALU class, it bypasses the FIFO. rf_* are registered directly from the ex_* inputs, so rf_wen is high in cycle N+1. LOAD/STORE and non-empty cases are unchanged.
- Undefined: every instruction goes through the FIFO (ALU latency N+2).

Test Plan:
- Reset with FIFO holding 2 entries and FSM in MEM_WAIT -> after reset all outputs 0, ex_ready=1; a later mem_rsp_valid pulse causes no rf_wen.
- Back-to-back ALU ops rd=3 (0x10) then rd=4 (0x20), warp=1 -> rf_wen in N+2 and N+3 with {3,0x10} then {4,0x20}; ex_ready stays 1.
- LOAD with addr 0x100, mem_req_ready low 3 cycles -> mem_req_valid and addr stable 4 cycles; rsp 0xDEADBEEF -> rf_wdata=0xDEADBEEF one cycle later.
- STORE addr 0x40 data 0x55, then ALU rd=5 -> req write=1; no rf_wen for the store; the ALU write follows the store handshake.
- LOAD stalled in MEM_WAIT plus 3 pushes -> ex_ready low after 2 entries; mem_rsp_valid while in IDLE is ignored.
- WB_BYPASS_EN build: single ALU op into an empty stage -> rf_wen in N+1. Non-bypass build: N+2.
